// File: rtl/tray_height_driver_if.sv
// Move-command channel for tray_height_driver: valid/ready handshake carrying the
// target height, plus an abort strobe for the move in progress.
interface tray_height_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_target;
  logic        abort;

  modport master (output cmd_valid, output cmd_target, output abort, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, input abort, output cmd_ready);
endinterface

// File: rtl/tray_height_driver.sv
// Ramps the tray height toward a commanded, clamped target by STEP per clock; one command at a time.
// Latency: first step one edge after accept, ceil(D/STEP) edges per move. Backpressure: cmd_ready only in IDLE.
// Optional macro TRAY_SETTLE_EN adds a SETTLE hold of SETTLE_CYCLES after arrival.
module tray_height_driver #(
  parameter logic [31:0] STEP          = 32'd1,
  parameter logic [31:0] MAX_HEIGHT    = 32'h0000_FFFF,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tray_height_driver_if.slave  cmd,
  output logic [31:0]          tray_height,
  output logic [7:0]           tray_station,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UP     = 2'd1,
`ifdef TRAY_SETTLE_EN
    ST_SETTLE = 2'd3,
`endif
    ST_DOWN   = 2'd2
  } state_t;

  localparam logic [7:0] STN_ZERO   = 8'h00;
  localparam logic [7:0] STN_STABLE = 8'h01;
  localparam logic [7:0] STN_UP     = 8'h02;
  localparam logic [7:0] STN_DOWN   = 8'h03;

  if (STEP == 32'd0 || SETTLE_CYCLES > 65535) begin : g_param_check
    $error("tray_height_driver: STEP must be >= 1 and SETTLE_CYCLES <= 65535");
  end

  state_t      r_state;
  logic [31:0] r_height;
  logic [31:0] r_target;
  logic        r_done;
  logic        r_aborted;
  logic        r_ready;
  logic        r_busy;
  logic [7:0]  r_station;

  state_t      w_nxt_state;
  logic [31:0] w_nxt_height;
  logic [31:0] w_nxt_target;
  logic        w_nxt_done;
  logic        w_nxt_aborted;
  logic [31:0] w_clamped;
  logic [31:0] w_up_gap;
  logic [31:0] w_dn_gap;

`ifdef TRAY_SETTLE_EN
  localparam logic [15:0] SETTLE_LOAD = (SETTLE_CYCLES <= 1) ? 16'd0 : 16'(SETTLE_CYCLES - 1);
  logic [15:0] r_settle_cnt;
  logic [15:0] w_nxt_settle_cnt;
`endif

  // Station is decoded from the state/height being registered, so it lines up with them.
  function automatic logic [7:0] station_of(input state_t s, input logic [31:0] h);
    if (s == ST_UP)        return STN_UP;
    else if (s == ST_DOWN) return STN_DOWN;
    else if (h == 32'd0)   return STN_ZERO;
    else                   return STN_STABLE;
  endfunction

  assign w_clamped = (cmd.cmd_target > MAX_HEIGHT) ? MAX_HEIGHT : cmd.cmd_target;
  assign w_up_gap  = r_target - r_height;
  assign w_dn_gap  = r_height - r_target;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_height  = r_height;
    w_nxt_target  = r_target;
    w_nxt_done    = 1'b0;
    w_nxt_aborted = 1'b0;
`ifdef TRAY_SETTLE_EN
    w_nxt_settle_cnt = r_settle_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (cmd.cmd_valid && r_ready) begin
          w_nxt_target = w_clamped;
          if (w_clamped > r_height)      w_nxt_state = ST_UP;
          else if (w_clamped < r_height) w_nxt_state = ST_DOWN;
          else                           w_nxt_done  = 1'b1;
        end
      end
      ST_UP, ST_DOWN: begin
        if (cmd.abort) begin
          w_nxt_state   = ST_IDLE;
          w_nxt_aborted = 1'b1;
        end else if (((r_state == ST_UP) ? w_up_gap : w_dn_gap) <= STEP) begin
          // Snap to the target rather than overshoot, so height never wraps.
          w_nxt_height = r_target;
`ifdef TRAY_SETTLE_EN
          w_nxt_state      = ST_SETTLE;
          w_nxt_settle_cnt = SETTLE_LOAD;
`else
          w_nxt_state = ST_IDLE;
          w_nxt_done  = 1'b1;
`endif
        end else if (r_state == ST_UP) begin
          w_nxt_height = r_height + STEP;
        end else begin
          w_nxt_height = r_height - STEP;
        end
      end
`ifdef TRAY_SETTLE_EN
      ST_SETTLE: begin
        if (cmd.abort) begin
          w_nxt_state   = ST_IDLE;
          w_nxt_aborted = 1'b1;
        end else if (r_settle_cnt == 16'd0) begin
          w_nxt_state = ST_IDLE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_settle_cnt = r_settle_cnt - 16'd1;
        end
      end
`endif
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_height  <= 32'd0;
      r_target  <= 32'd0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_station <= STN_ZERO;
`ifdef TRAY_SETTLE_EN
      r_settle_cnt <= 16'd0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_height  <= w_nxt_height;
      r_target  <= w_nxt_target;
      r_done    <= w_nxt_done;
      r_aborted <= w_nxt_aborted;
      r_ready   <= (w_nxt_state == ST_IDLE);
      r_busy    <= (w_nxt_state != ST_IDLE);
      r_station <= station_of(w_nxt_state, w_nxt_height);
`ifdef TRAY_SETTLE_EN
      r_settle_cnt <= w_nxt_settle_cnt;
`endif
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign tray_height   = r_height;
  assign tray_station  = r_station;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;

endmodule

// File: tb/tb_tray_height_driver.sv
// Directed bench for tray_height_driver: instance A (STEP=4) covers moves, abort, equal target,
// back-to-back and async reset; instance B (STEP=0x4000) covers target clamping.
module tb_tray_height_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  tray_height_driver_if if_a();
  tray_height_driver_if if_b();

  logic [31:0] a_height, b_height;
  logic [7:0]  a_station, b_station;
  logic        a_busy, a_done, a_aborted, b_busy, b_done, b_aborted;

  tray_height_driver #(.STEP(32'd4), .MAX_HEIGHT(32'h0000_FFFF), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(if_a.slave),
    .tray_height(a_height), .tray_station(a_station),
    .busy(a_busy), .done(a_done), .aborted(a_aborted));

  tray_height_driver #(.STEP(32'h0000_4000), .MAX_HEIGHT(32'h0000_FFFF), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd(if_b.slave),
    .tray_height(b_height), .tray_station(b_station),
    .busy(b_busy), .done(b_done), .aborted(b_aborted));

  always #5 clk = ~clk;

  task automatic send_a(input logic [31:0] tgt);
    if_a.cmd_valid = 1'b1; if_a.cmd_target = tgt;
    @(negedge clk);
    if_a.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (a_height !== 32'd0) begin errors++; $display("FAIL reset_height: got %0h want 0", a_height); end
    checks++; if (a_station !== 8'h00) begin errors++; $display("FAIL reset_station: got %0h want 00", a_station); end
    checks++; if ({if_a.cmd_ready, a_busy, a_done, a_aborted} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got ready/busy/done/aborted=%b want 1000", {if_a.cmd_ready, a_busy, a_done, a_aborted}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({if_a.cmd_ready, a_busy, a_done, b_busy} !== 4'b1000) begin
      errors++; $display("FAIL post_reset_idle: got %b want 1000", {if_a.cmd_ready, a_busy, a_done, b_busy}); end
  endtask

  task automatic test_up;
    logic [31:0] exp_h [3];
    exp_h = '{32'd4, 32'd8, 32'd10};
    send_a(32'd10);
    checks++; if ({a_busy, if_a.cmd_ready, a_station} !== {2'b10, 8'h02} || a_height !== 32'd0) begin
      errors++; $display("FAIL up_accept: got busy/ready=%b station=%h h=%0d want 10 02 0", {a_busy, if_a.cmd_ready}, a_station, a_height); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_height !== exp_h[i]) begin errors++; $display("FAIL up_height[%0d]: got %0d want %0d", i, a_height, exp_h[i]); end
      if (i < 2) begin
        checks++; if (a_station !== 8'h02 || a_done !== 1'b0) begin
          errors++; $display("FAIL up_moving[%0d]: got station=%h done=%b want 02 0", i, a_station, a_done); end
      end
    end
    checks++; if ({a_done, a_busy, if_a.cmd_ready} !== 3'b101 || a_station !== 8'h01) begin
      errors++; $display("FAIL up_done: got done/busy/ready=%b station=%h want 101 01", {a_done, a_busy, if_a.cmd_ready}, a_station); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL up_done_pulse: got %b want 0", a_done); end
  endtask

  task automatic test_down;
    logic [31:0] exp_h [3];
    int n_done;
    exp_h = '{32'd6, 32'd2, 32'd0};
    n_done = 0;
    send_a(32'd0);
    checks++; if (a_station !== 8'h03) begin errors++; $display("FAIL down_accept_station: got %h want 03", a_station); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_done += int'(a_done);
      checks++; if (a_height !== exp_h[i]) begin errors++; $display("FAIL down_height[%0d]: got %0d want %0d", i, a_height, exp_h[i]); end
      if (i < 2) begin
        checks++; if (a_station !== 8'h03) begin errors++; $display("FAIL down_station[%0d]: got %h want 03", i, a_station); end
      end
    end
    checks++; if (a_station !== 8'h00) begin errors++; $display("FAIL down_final_station: got %h want 00", a_station); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_done += int'(a_done);
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL down_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_abort;
    send_a(32'd100);
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_height !== 32'd8) begin errors++; $display("FAIL abort_pre_height: got %0d want 8", a_height); end
    if_a.abort = 1'b1;
    @(negedge clk);
    if_a.abort = 1'b0;
    checks++; if (a_height !== 32'd8) begin errors++; $display("FAIL abort_frozen: got %0d want 8", a_height); end
    checks++; if ({a_aborted, a_done, if_a.cmd_ready, a_busy} !== 4'b1010 || a_station !== 8'h01) begin
      errors++; $display("FAIL abort_flags: got aborted/done/ready/busy=%b station=%h want 1010 01", {a_aborted, a_done, if_a.cmd_ready, a_busy}, a_station); end
    @(negedge clk);
    checks++; if ({a_aborted, a_done} !== 2'b00 || a_height !== 32'd8) begin
      errors++; $display("FAIL abort_after: got aborted/done=%b h=%0d want 00 8", {a_aborted, a_done}, a_height); end
  endtask

  task automatic test_equal;
    send_a(32'd8);
    checks++; if ({a_done, a_busy, if_a.cmd_ready} !== 3'b101 || a_height !== 32'd8) begin
      errors++; $display("FAIL equal_done: got done/busy/ready=%b h=%0d want 101 8", {a_done, a_busy, if_a.cmd_ready}, a_height); end
    @(negedge clk);
    checks++; if ({a_done, a_busy} !== 2'b00 || a_height !== 32'd8) begin
      errors++; $display("FAIL equal_after: got done/busy=%b h=%0d want 00 8", {a_done, a_busy}, a_height); end
  endtask

  task automatic test_back_to_back;
    send_a(32'd12);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL b2b_first_busy: got %b want 1", a_busy); end
    @(negedge clk);
    checks++; if ({a_done, if_a.cmd_ready} !== 2'b11 || a_height !== 32'd12) begin
      errors++; $display("FAIL b2b_first_done: got done/ready=%b h=%0d want 11 12", {a_done, if_a.cmd_ready}, a_height); end
    send_a(32'd4);
    checks++; if ({a_busy, a_done} !== 2'b10 || a_station !== 8'h03 || a_height !== 32'd12) begin
      errors++; $display("FAIL b2b_second_accept: got busy/done=%b station=%h h=%0d want 10 03 12", {a_busy, a_done}, a_station, a_height); end
    @(negedge clk);
    checks++; if (a_height !== 32'd8) begin errors++; $display("FAIL b2b_step: got %0d want 8", a_height); end
    @(negedge clk);
    checks++; if (a_height !== 32'd4 || a_done !== 1'b1) begin
      errors++; $display("FAIL b2b_second_done: got h=%0d done=%b want 4 1", a_height, a_done); end
  endtask

  task automatic test_clamp;
    logic [31:0] exp_h [4];
    exp_h = '{32'h0000_4000, 32'h0000_8000, 32'h0000_C000, 32'h0000_FFFF};
    if_b.cmd_valid = 1'b1; if_b.cmd_target = 32'hFFFF_FFFF;
    @(negedge clk);
    if_b.cmd_valid = 1'b0;
    checks++; if (b_station !== 8'h02) begin errors++; $display("FAIL clamp_accept: got station %h want 02", b_station); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (b_height !== exp_h[i]) begin errors++; $display("FAIL clamp_height[%0d]: got %h want %h", i, b_height, exp_h[i]); end
    end
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL clamp_done: got %b want 1", b_done); end
    @(negedge clk);
    checks++; if (b_height !== 32'h0000_FFFF || b_busy !== 1'b0) begin
      errors++; $display("FAIL clamp_hold: got h=%h busy=%b want 0000ffff 0", b_height, b_busy); end
  endtask

  task automatic test_async_reset;
    int n_pulse;
    n_pulse = 0;
    send_a(32'd100);
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_height !== 32'd12 || a_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_move: got h=%0d busy=%b want 12 1", a_height, a_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_height !== 32'd0 || a_station !== 8'h00) begin
      errors++; $display("FAIL rst_async_height: got h=%0d station=%h want 0 00", a_height, a_station); end
    checks++; if ({if_a.cmd_ready, a_busy, a_done, a_aborted} !== 4'b1000) begin
      errors++; $display("FAIL rst_async_flags: got %b want 1000", {if_a.cmd_ready, a_busy, a_done, a_aborted}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_pulse += int'(a_done) + int'(a_aborted);
    end
    checks++; if (n_pulse != 0 || a_height !== 32'd0 || if_a.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_after: got pulses=%0d h=%0d ready=%b want 0 0 1", n_pulse, a_height, if_a.cmd_ready); end
  endtask

`ifdef TRAY_SETTLE_EN
  task automatic test_settle;
    int n_done;
    n_done = 0;
    send_a(32'd4);
    @(negedge clk);
    checks++; if (a_height !== 32'd4 || a_station !== 8'h01) begin
      errors++; $display("FAIL settle_arrive: got h=%0d station=%h want 4 01", a_height, a_station); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if ({a_busy, if_a.cmd_ready, a_done} !== 3'b100) begin
        errors++; $display("FAIL settle_hold[%0d]: got busy/ready/done=%b want 100", i, {a_busy, if_a.cmd_ready, a_done}); end
    end
    @(negedge clk);
    checks++; if ({a_busy, if_a.cmd_ready, a_done} !== 3'b011) begin
      errors++; $display("FAIL settle_done: got busy/ready/done=%b want 011", {a_busy, if_a.cmd_ready, a_done}); end
    send_a(32'd8);
    @(negedge clk);
    if_a.abort = 1'b1;
    @(negedge clk);
    if_a.abort = 1'b0;
    checks++; if ({a_aborted, a_done, a_busy} !== 3'b100 || a_height !== 32'd8) begin
      errors++; $display("FAIL settle_abort: got aborted/done/busy=%b h=%0d want 100 8", {a_aborted, a_done, a_busy}, a_height); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_done += int'(a_done);
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL settle_abort_no_done: got %0d want 0", n_done); end
  endtask
`endif

  initial begin
    if_a.cmd_valid = 1'b0; if_a.cmd_target = 32'd0; if_a.abort = 1'b0;
    if_b.cmd_valid = 1'b0; if_b.cmd_target = 32'd0; if_b.abort = 1'b0;
    test_reset();
`ifdef TRAY_SETTLE_EN
    test_settle();
`else
    test_up();
    test_down();
    test_abort();
    test_equal();
    test_back_to_back();
    test_clamp();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
